sound_frame_mixer: RTL and testbench



---
 rtl/sound_frame_mixer_pkg.sv | 20 ++
 rtl/sound_frame_mixer_if.sv | 24 ++
 rtl/sound_frame_mixer_sequencer.sv | 45 ++++
 rtl/sound_frame_mixer.sv | 150 +++++++++++++++
 tb/tb_sound_frame_mixer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sound_frame_mixer_pkg.sv
// Shared types, step-decode constants and width helper for the sound frame mixer.
package sound_pkg;

    // Mixer FSM encoding, kept as plain constants for legacy tools.
    typedef logic [1:0] mix_state_t;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_SCALE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Bit n set means the strobe fires when the sequencer lands on step n.
    localparam logic [7:0] FS_LENGTH_STEPS = 8'b0101_0101;
    localparam logic [7:0] FS_SWEEP_STEPS  = 8'b0100_0100;
    localparam logic [2:0] FS_ENV_STEP     = 3'd7;

    function automatic int mix_width(input int num_ch, input int level_w, input bit is_signed);
        return level_w + (is_signed ? 1 : 0) + $clog2(num_ch) + 3;
    endfunction

endpackage

// File: rtl/sound_frame_mixer_if.sv
// Sample handshake between the mixer (slave) and the AC97 frame logic (master).
interface sound_frame_mixer_if;
    logic        sample_req;
    logic        sample_ack;
    logic        sample_valid;
    logic [15:0] sample_so1;
    logic [15:0] sample_so2;

    modport master (
        output sample_req,
        output sample_ack,
        input  sample_valid,
        input  sample_so1,
        input  sample_so2
    );

    modport slave (
        input  sample_req,
        input  sample_ack,
        output sample_valid,
        output sample_so1,
        output sample_so2
    );
endinterface

// File: rtl/sound_frame_mixer_sequencer.sv
// Fractional-accumulator frame sequencer: carry out of the phase accumulator
// advances the 8-step counter and emits registered one-cycle tick strobes.
module sound_frame_sequencer
    import sound_pkg::*;
#(
    parameter int ACC_W  = 24,
    parameter int FS_INC = 699
) (
    input  logic       ac97_bitclk,
    input  logic       reset,
    input  logic       enable,
    output logic       length_tick,
    output logic       sweep_tick,
    output logic       envelope_tick,
    output logic [2:0] fs_step
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;
    logic [2:0]       step_next;
    logic             carry;

    assign acc_sum   = {1'b0, acc} + (ACC_W+1)'(FS_INC);
    assign carry     = acc_sum[ACC_W];
    assign step_next = fs_step + 3'd1;

    // Strobes decode the step being entered so they line up with the fs_step update.
    always_ff @(posedge ac97_bitclk) begin
        if (reset || !enable) begin
            acc           <= '0;
            fs_step       <= '0;
            length_tick   <= 1'b0;
            sweep_tick    <= 1'b0;
            envelope_tick <= 1'b0;
        end else begin
            acc           <= acc_sum[ACC_W-1:0];
            length_tick   <= carry && FS_LENGTH_STEPS[step_next];
            sweep_tick    <= carry && FS_SWEEP_STEPS[step_next];
            envelope_tick <= carry && (step_next == FS_ENV_STEP);
            if (carry)
                fs_step <= step_next;
        end
    end

endmodule

// File: rtl/sound_frame_mixer.sv
// Frame sequencer plus NUM_CH-channel SO1/SO2 mixer with req/valid/ack delivery.
// Define SOUND_MIXER_SIGNED_DAC_EN for a signed, zero-centred DAC transfer.
module sound_frame_mixer
    import sound_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int LEVEL_W = 4,
    parameter int ACC_W   = 24,
    parameter int FS_INC  = 699
) (
    input  logic                      ac97_bitclk,
    input  logic                      reset,
    input  logic                      master_sound_enable,
    input  logic [NUM_CH*LEVEL_W-1:0] ch_level,
    input  logic [NUM_CH-1:0]         so1_enable,
    input  logic [NUM_CH-1:0]         so2_enable,
    input  logic [2:0]                so1_output_level,
    input  logic [2:0]                so2_output_level,
    sound_frame_mixer_if.slave        smp,
    output logic                      length_tick,
    output logic                      sweep_tick,
    output logic                      envelope_tick,
    output logic [2:0]                fs_step,
    output logic                      overrun
);

`ifdef SOUND_MIXER_SIGNED_DAC_EN
    localparam bit SIGNED_DAC = 1'b1;
`else
    localparam bit SIGNED_DAC = 1'b0;
`endif
    localparam int MIX_W = mix_width(NUM_CH, LEVEL_W, SIGNED_DAC);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (MIX_W > 16) begin : g_mix_w_check
        $error("sound_frame_mixer: mix width exceeds the 16-bit sample");
    end

    // Sums live at full mix width; two's complement wrap makes signed and unsigned share the adder.
    function automatic logic [MIX_W-1:0] dac(input logic [LEVEL_W-1:0] level);
`ifdef SOUND_MIXER_SIGNED_DAC_EN
        int v;
        v = 2 * int'(level) - (2**LEVEL_W - 1);
        return v[MIX_W-1:0];
`else
        return MIX_W'(level);
`endif
    endfunction

    sound_frame_sequencer #(
        .ACC_W  (ACC_W),
        .FS_INC (FS_INC)
    ) u_seq (
        .ac97_bitclk   (ac97_bitclk),
        .reset         (reset),
        .enable        (master_sound_enable),
        .length_tick   (length_tick),
        .sweep_tick    (sweep_tick),
        .envelope_tick (envelope_tick),
        .fs_step       (fs_step)
    );

    mix_state_t                state;
    logic [IDX_W-1:0]          idx;
    logic [NUM_CH*LEVEL_W-1:0] snap_level;
    logic [NUM_CH-1:0]         snap_so1_en;
    logic [NUM_CH-1:0]         snap_so2_en;
    logic [2:0]                snap_vol1;
    logic [2:0]                snap_vol2;
    logic [MIX_W-1:0]          sum1;
    logic [MIX_W-1:0]          sum2;
    logic [MIX_W-1:0]          dac_val;
    logic [MIX_W-1:0]          gain1;
    logic [MIX_W-1:0]          gain2;
    logic [MIX_W-1:0]          prod1;
    logic [MIX_W-1:0]          prod2;
    logic                      start;

    assign start   = smp.sample_req &&
                     ((state == ST_IDLE) || ((state == ST_DONE) && smp.sample_ack));
    assign dac_val = dac(snap_level[int'(idx)*LEVEL_W +: LEVEL_W]);
    assign gain1   = MIX_W'(snap_vol1) + MIX_W'(1);
    assign gain2   = MIX_W'(snap_vol2) + MIX_W'(1);
    assign prod1   = sum1 * gain1;
    assign prod2   = sum2 * gain2;

    // With audio disabled at snapshot time the routing is zeroed, so both sums stay at 0.
    always_ff @(posedge ac97_bitclk) begin
        if (reset) begin
            state            <= ST_IDLE;
            idx              <= '0;
            snap_level       <= '0;
            snap_so1_en      <= '0;
            snap_so2_en      <= '0;
            snap_vol1        <= '0;
            snap_vol2        <= '0;
            sum1             <= '0;
            sum2             <= '0;
            overrun          <= 1'b0;
            smp.sample_valid <= 1'b0;
            smp.sample_so1   <= '0;
            smp.sample_so2   <= '0;
        end else begin
            if (start) begin
                snap_level  <= ch_level;
                snap_so1_en <= master_sound_enable ? so1_enable : '0;
                snap_so2_en <= master_sound_enable ? so2_enable : '0;
                snap_vol1   <= so1_output_level;
                snap_vol2   <= so2_output_level;
                sum1        <= '0;
                sum2        <= '0;
                idx         <= '0;
                state       <= ST_ACCUM;
            end
            case (state)
                ST_ACCUM: begin
                    if (snap_so1_en[idx])
                        sum1 <= sum1 + dac_val;
                    if (snap_so2_en[idx])
                        sum2 <= sum2 + dac_val;
                    if (idx == IDX_W'(NUM_CH - 1))
                        state <= ST_SCALE;
                    else
                        idx <= idx + 1'b1;
                    if (smp.sample_req)
                        overrun <= 1'b1;
                end
                ST_SCALE: begin
                    smp.sample_so1   <= 16'(prod1) << (16 - MIX_W);
                    smp.sample_so2   <= 16'(prod2) << (16 - MIX_W);
                    smp.sample_valid <= 1'b1;
                    state            <= ST_DONE;
                    if (smp.sample_req)
                        overrun <= 1'b1;
                end
                ST_DONE: begin
                    if (smp.sample_ack) begin
                        smp.sample_valid <= 1'b0;
                        if (!smp.sample_req)
                            state <= ST_IDLE;
                    end else if (smp.sample_req) begin
                        overrun <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sound_frame_mixer.sv
// Directed self-checking bench: default mixer instance plus a fast-sequencer instance.
module tb_sound_frame_mixer;

`ifdef SOUND_MIXER_SIGNED_DAC_EN
    localparam logic [15:0] EXP_FULL = 16'h7800;
    localparam logic [15:0] EXP_ZLVL = 16'h8800;
    localparam logic [15:0] EXP_MIX1 = 16'hEF80;
    localparam logic [15:0] EXP_MIX2 = 16'hF940;
`else
    localparam logic [15:0] EXP_FULL = 16'hF000;
    localparam logic [15:0] EXP_ZLVL = 16'h0000;
    localparam logic [15:0] EXP_MIX1 = 16'h0600;
    localparam logic [15:0] EXP_MIX2 = 16'h0480;
`endif

    logic        clk;
    logic        reset;
    logic        master_en;
    logic        seq_en;
    logic [15:0] ch_level;
    logic [3:0]  so1_en;
    logic [3:0]  so2_en;
    logic [2:0]  vol1;
    logic [2:0]  vol2;
    logic        len_t, sw_t, env_t, ovr;
    logic [2:0]  step;
    logic        seq_len, seq_sw, seq_env, seq_ovr;
    logic [2:0]  seq_step;

    int checks = 0;
    int passed = 0;

    sound_frame_mixer_if mix_if ();
    sound_frame_mixer_if seq_if ();

    sound_frame_mixer #(.NUM_CH(4), .LEVEL_W(4)) dut (
        .ac97_bitclk         (clk),
        .reset               (reset),
        .master_sound_enable (master_en),
        .ch_level            (ch_level),
        .so1_enable          (so1_en),
        .so2_enable          (so2_en),
        .so1_output_level    (vol1),
        .so2_output_level    (vol2),
        .smp                 (mix_if),
        .length_tick         (len_t),
        .sweep_tick          (sw_t),
        .envelope_tick       (env_t),
        .fs_step             (step),
        .overrun             (ovr)
    );

    sound_frame_mixer #(.NUM_CH(4), .LEVEL_W(4), .ACC_W(4), .FS_INC(8)) seq_dut (
        .ac97_bitclk         (clk),
        .reset               (reset),
        .master_sound_enable (seq_en),
        .ch_level            (16'h0000),
        .so1_enable          (4'h0),
        .so2_enable          (4'h0),
        .so1_output_level    (3'd0),
        .so2_output_level    (3'd0),
        .smp                 (seq_if),
        .length_tick         (seq_len),
        .sweep_tick          (seq_sw),
        .envelope_tick       (seq_env),
        .fs_step             (seq_step),
        .overrun             (seq_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic [15:0] lv, input logic [3:0] e1, input logic [3:0] e2,
                              input logic [2:0] v1, input logic [2:0] v2);
        ch_level = lv;
        so1_en   = e1;
        so2_en   = e2;
        vol1     = v1;
        vol2     = v2;
    endtask

    task automatic pulse_req();
        mix_if.sample_req = 1'b1;
        tick();
        mix_if.sample_req = 1'b0;
    endtask

    task automatic ack_sample();
        mix_if.sample_ack = 1'b1;
        tick();
        mix_if.sample_ack = 1'b0;
    endtask

    // Returns the request-to-valid latency including the accepting cycle, or -1 on timeout.
    task automatic wait_valid(output int lat);
        int c = 0;
        while (!mix_if.sample_valid && c < 20) begin
            tick();
            c++;
        end
        lat = mix_if.sample_valid ? c + 1 : -1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (mix_if.sample_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", mix_if.sample_valid); else passed++;
        checks++; if (mix_if.sample_so1 !== 16'h0) $display("[TB] FAIL reset_so1: got %h expected 0000", mix_if.sample_so1); else passed++;
        checks++; if (mix_if.sample_so2 !== 16'h0) $display("[TB] FAIL reset_so2: got %h expected 0000", mix_if.sample_so2); else passed++;
        checks++; if (ovr !== 1'b0) $display("[TB] FAIL reset_overrun: got %b expected 0", ovr); else passed++;
        checks++; if (step !== 3'd0) $display("[TB] FAIL reset_fs_step: got %0d expected 0", step); else passed++;
        checks++; if ({len_t, sw_t, env_t} !== 3'b000) $display("[TB] FAIL reset_ticks: got %b expected 000", {len_t, sw_t, env_t}); else passed++;
    endtask

    task automatic test_frame_seq();
        logic [2:0] exp_step;
        logic [5:0] exp_v;
        seq_en = 1'b0;
        tick();
        checks++; if ({seq_step, seq_len, seq_sw, seq_env} !== 6'd0) $display("[TB] FAIL seq_disabled: got %b expected 000000", {seq_step, seq_len, seq_sw, seq_env}); else passed++;
        seq_en   = 1'b1;
        exp_step = 3'd0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k % 2 == 0) begin
                exp_step = exp_step + 3'd1;
                exp_v = {exp_step, ~exp_step[0], (exp_step == 3'd2 || exp_step == 3'd6), (exp_step == 3'd7)};
            end else begin
                exp_v = {exp_step, 3'b000};
            end
            checks++;
            if ({seq_step, seq_len, seq_sw, seq_env} !== exp_v)
                $display("[TB] FAIL seq_cycle%0d: got step=%0d ticks=%b expected step=%0d ticks=%b",
                         k, seq_step, {seq_len, seq_sw, seq_env}, exp_v[5:3], exp_v[2:0]);
            else passed++;
        end
        seq_en = 1'b0;
        tick();
        checks++; if ({seq_step, seq_len, seq_sw, seq_env} !== 6'd0) $display("[TB] FAIL seq_clear: got %b expected 000000", {seq_step, seq_len, seq_sw, seq_env}); else passed++;
        seq_en = 1'b1;
    endtask

    task automatic test_single_sample();
        int lat;
        master_en = 1'b1;
        set_inputs(16'hFFFF, 4'hF, 4'h0, 3'd7, 3'd0);
        pulse_req();
        wait_valid(lat);
        checks++; if (lat !== 6) $display("[TB] FAIL full_latency: got %0d expected 6", lat); else passed++;
        checks++; if (mix_if.sample_so1 !== EXP_FULL) $display("[TB] FAIL full_so1: got %h expected %h", mix_if.sample_so1, EXP_FULL); else passed++;
        checks++; if (mix_if.sample_so2 !== 16'h0) $display("[TB] FAIL full_so2: got %h expected 0000", mix_if.sample_so2); else passed++;
        set_inputs(16'h0000, 4'h0, 4'hF, 3'd0, 3'd7);
        repeat (3) tick();
        checks++; if ({mix_if.sample_valid, mix_if.sample_so1} !== {1'b1, EXP_FULL}) $display("[TB] FAIL full_hold: got valid=%b so1=%h expected valid=1 so1=%h", mix_if.sample_valid, mix_if.sample_so1, EXP_FULL); else passed++;
        ack_sample();
        checks++; if (mix_if.sample_valid !== 1'b0) $display("[TB] FAIL ack_drop: got %b expected 0", mix_if.sample_valid); else passed++;
        tick();
    endtask

    task automatic test_patterns();
        int lat;
        set_inputs(16'h4321, 4'b0101, 4'b1110, 3'd2, 3'd0);
        pulse_req();
        wait_valid(lat);
        checks++; if (mix_if.sample_so1 !== EXP_MIX1) $display("[TB] FAIL mix_so1: got %h expected %h", mix_if.sample_so1, EXP_MIX1); else passed++;
        checks++; if (mix_if.sample_so2 !== EXP_MIX2) $display("[TB] FAIL mix_so2: got %h expected %h", mix_if.sample_so2, EXP_MIX2); else passed++;
        ack_sample();
        set_inputs(16'h0000, 4'hF, 4'h0, 3'd7, 3'd0);
        pulse_req();
        wait_valid(lat);
        checks++; if (mix_if.sample_so1 !== EXP_ZLVL) $display("[TB] FAIL zero_level_so1: got %h expected %h", mix_if.sample_so1, EXP_ZLVL); else passed++;
        ack_sample();
        master_en = 1'b0;
        set_inputs(16'hFFFF, 4'hF, 4'hF, 3'd7, 3'd7);
        pulse_req();
        master_en = 1'b1;
        wait_valid(lat);
        checks++; if (lat !== 6) $display("[TB] FAIL muted_latency: got %0d expected 6", lat); else passed++;
        checks++; if ({mix_if.sample_so1, mix_if.sample_so2} !== 32'h0) $display("[TB] FAIL muted_samples: got %h/%h expected 0000/0000", mix_if.sample_so1, mix_if.sample_so2); else passed++;
        ack_sample();
        tick();
    endtask

    task automatic test_overrun();
        int lat;
        int valids;
        pulse_reset();
        checks++; if (ovr !== 1'b0) $display("[TB] FAIL overrun_cleared: got %b expected 0", ovr); else passed++;
        set_inputs(16'hFFFF, 4'hF, 4'h0, 3'd7, 3'd0);
        pulse_req();
        tick();
        tick();
        pulse_req();
        checks++; if (ovr !== 1'b1) $display("[TB] FAIL overrun_set: got %b expected 1", ovr); else passed++;
        wait_valid(lat);
        valids = mix_if.sample_valid ? 1 : 0;
        ack_sample();
        for (int i = 0; i < 15; i++) begin
            tick();
            if (mix_if.sample_valid) valids++;
        end
        checks++; if (valids !== 1) $display("[TB] FAIL overrun_valids: got %0d expected 1", valids); else passed++;
        checks++; if (ovr !== 1'b1) $display("[TB] FAIL overrun_sticky: got %b expected 1", ovr); else passed++;
    endtask

    task automatic test_back_to_back();
        int lat;
        int low;
        pulse_reset();
        set_inputs(16'hFFFF, 4'hF, 4'h0, 3'd7, 3'd0);
        pulse_req();
        wait_valid(lat);
        checks++; if (mix_if.sample_so1 !== EXP_FULL) $display("[TB] FAIL b2b_first_so1: got %h expected %h", mix_if.sample_so1, EXP_FULL); else passed++;
        set_inputs(16'h4321, 4'b0101, 4'b1110, 3'd2, 3'd0);
        mix_if.sample_ack = 1'b1;
        mix_if.sample_req = 1'b1;
        tick();
        mix_if.sample_ack = 1'b0;
        mix_if.sample_req = 1'b0;
        low = mix_if.sample_valid ? 0 : 1;
        while (!mix_if.sample_valid && low < 20) begin
            tick();
            if (!mix_if.sample_valid) low++;
        end
        checks++; if (low !== 5) $display("[TB] FAIL b2b_low_cycles: got %0d expected 5", low); else passed++;
        checks++; if ({mix_if.sample_so1, mix_if.sample_so2} !== {EXP_MIX1, EXP_MIX2}) $display("[TB] FAIL b2b_second: got %h/%h expected %h/%h", mix_if.sample_so1, mix_if.sample_so2, EXP_MIX1, EXP_MIX2); else passed++;
        checks++; if (ovr !== 1'b0) $display("[TB] FAIL b2b_overrun: got %b expected 0", ovr); else passed++;
        ack_sample();
    endtask

    task automatic test_reset_mid();
        int lat;
        int valids = 0;
        set_inputs(16'hFFFF, 4'hF, 4'hF, 3'd7, 3'd7);
        pulse_req();
        tick();
        pulse_reset();
        checks++; if ({mix_if.sample_valid, mix_if.sample_so1, mix_if.sample_so2, ovr} !== 34'h0) $display("[TB] FAIL midreset_outputs: got valid=%b so1=%h so2=%h ovr=%b expected all 0", mix_if.sample_valid, mix_if.sample_so1, mix_if.sample_so2, ovr); else passed++;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mix_if.sample_valid) valids++;
        end
        checks++; if (valids !== 0) $display("[TB] FAIL midreset_abort: got %0d valid cycles expected 0", valids); else passed++;
        set_inputs(16'h0000, 4'hF, 4'h0, 3'd7, 3'd0);
        pulse_req();
        wait_valid(lat);
        checks++; if (lat !== 6) $display("[TB] FAIL midreset_latency: got %0d expected 6", lat); else passed++;
        checks++; if (mix_if.sample_so1 !== EXP_ZLVL) $display("[TB] FAIL midreset_so1: got %h expected %h", mix_if.sample_so1, EXP_ZLVL); else passed++;
        ack_sample();
    endtask

    initial begin
        reset             = 1'b1;
        master_en         = 1'b1;
        seq_en            = 1'b1;
        mix_if.sample_req = 1'b0;
        mix_if.sample_ack = 1'b0;
        seq_if.sample_req = 1'b0;
        seq_if.sample_ack = 1'b0;
        set_inputs(16'h0000, 4'h0, 4'h0, 3'd0, 3'd0);
        test_reset();
        test_frame_seq();
        test_single_sample();
        test_patterns();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
